memory_access: RTL and testbench
================================

# memory_access

Pipeline memory stage of the MIPS core, directly upstream of the writeback stage. Accepts one `content_t` from execute, performs at most one data-bus access (load or store) via the `dbus` request/response handshake, fills `val.valM` for loads, and registers the result into the memory/writeback pipeline register. Stalls upstream while an access is outstanding.

## Interface
Parameters:
- none (widths come from `cpuhead.svh`)

Ports:
- `clk`  in  1  core clock
- `resetn`  in  1  reset: synchronous, active-low; one clock, all state updates on rising `clk`
- `in_cont`  in  `content_t`  instruction from execute; `val.valE` = address/ALU result, `val.valB` = store data
- `in_valid`  in  1  `in_cont` holds a real instruction
- `in_ready`  out  1  stage can accept this cycle
- `mem_stall`  out  1  `~in_ready`, to hazard unit
- `out_cont`  out  `content_t`  registered content to writeback
- `out_valid`  out  1  `out_cont` is a real instruction (bubble otherwise)
- `dreq`  out  `dbus_req_t`  {valid, addr, size, strobe, data}
- `dresp`  in  `dbus_resp_t`  {addr_ok, data_ok, data}

## Operation
- FSM states: `IDLE`, `REQ` (waiting addr_ok), `WAIT` (waiting data_ok).
- `in_ready = (state == IDLE)`. Accept = `in_valid & in_ready`.
- Accept, non-memory op (`mem_control.read_en == 0 && write_en == 0`): `out_cont <= in_cont`, `out_valid <= 1`; stay `IDLE`.
- Accept, memory op: latch `in_cont` in holding register, build request, `IDLE -> REQ`; `out_valid <= 0`.
- No accept in `IDLE`: `out_valid <= 0`, `out_cont` holds.
- `REQ`: `dreq.valid = 1`, all `dreq` fields stable from holding register. `addr_ok & ~data_ok -> WAIT`. `addr_ok & data_ok` -> complete. No `addr_ok` -> stay.
- `WAIT`: `dreq.valid = 0`. `data_ok` -> complete. Else stay.
- Complete: `out_cont <=` holding register with `val.valM` = extracted load data (loads only; stores leave valM unchanged), `out_valid <= 1`, state `-> IDLE`.
- `data_ok` in `IDLE` ignored.
- Request build (`mem_control.size`, addr = `valE`, `a = valE[1:0]`):
  - byte: strobe `4'b0001 << a`, data = byte of `valB` replicated to 4 lanes.
  - half: strobe `4'b0011 << {a[1],1'b0}`, data = `{valB[15:0], valB[15:0]}`.
  - word: strobe `4'b1111`, data = `valB`.
  - loads: strobe `4'b0000`.
- Load extract: lane = `dresp.data >> (8*a)` (half uses `a[1]`); low 8/16 bits sign-extended if `mem_control.sign_ext` else zero-extended; word unchanged.
- Misalignment not checked here; address issued unmodified.

## Timing
- Reset values: `out_cont = '0`, `out_valid = 0`, `dreq = '0`, state `IDLE` (so `in_ready = 1`, `mem_stall = 0`).
- Non-memory latency: accepted cycle T -> `out_valid` at T+1.
- Memory op, zero-wait bus: accept T, `dreq.valid` T+1, `addr_ok` T+1, `data_ok` T+2, `out_valid` T+3, `in_ready` high at T+3.
- `addr_ok` and `data_ok` same cycle in `REQ`: `out_valid` next cycle, skips `WAIT`.
- `in_ready`, `mem_stall`, `dreq.valid` are functions of state only (no combinational path from `in_valid`/`dresp`).
- `resetn` low mid-access: next edge -> `IDLE`, `dreq.valid = 0`, `out_valid = 0`; in-flight load result discarded, later `data_ok` ignored.
- Writeback always consumes; no backpressure on `out_*`.

## Structure
- `cpuhead.svh`: `msize_t` (`MSIZE1`, `MSIZE2`, `MSIZE4`), `mem_state_t`, `dbus_req_t`, `dbus_resp_t`, `mem_control.sign_ext` and `size` fields.
- Sub-module `mem_align`: combinational strobe/data lane generation and load extract/extend; FSM and registers stay in `memory_access`.

## Test plan
- ALU op, `valE = 32'h1234` -> `out_valid` next cycle, `out_cont.val.valE = 32'h1234`, `dreq.valid` never high.
- `lw`, addr `32'h80000004`, addr_ok/data_ok with 0 waits, data `32'hdeadbeef` -> `out_valid` 3 cycles after accept, `valM = 32'hdeadbeef`, `in_ready` low 2 cycles.
- `lb` signed, addr low bits 2'b11, data `32'h80aabbcc` -> `valM = 32'hffffff80`; `lbu` same -> `32'h00000080`; `lh` signed addr 2'b10, data `32'h8001xxxx` -> `32'hffff8001`.
- `sb` addr low bits 2'b01, `valB = 32'h000000ab`, addr_ok delayed 3 cycles -> `dreq` stable all 4 cycles, strobe `4'b0010`, data `32'habababab`.
- `sw` with addr_ok and data_ok asserted same cycle -> no `WAIT` visit, `out_valid` next cycle.
- `resetn` low during `WAIT`, then stray `data_ok` -> `out_valid` stays 0, state `IDLE`, next ALU op passes in 1 cycle.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: access size, FSM state, pipeline
// content and the data-bus request/response records.
package memory_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic   read_en;
        logic   write_en;
        logic   sign_ext;
        msize_t size;
    } mem_control_t;

    typedef struct packed {
        logic [31:0] valE;
        logic [31:0] valB;
        logic [31:0] valM;
    } val_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [4:0]   dst;
        mem_control_t mem_control;
        val_t         val;
    } content_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/memory_access_align.sv
// Byte-lane steering for the data bus: store strobe/data replication on the
// request side, lane select plus sign/zero extension on the load side.
module mem_align
    import memory_access_pkg::*;
(
    input  msize_t      size,
    input  logic [1:0]  addr_lo,
    input  logic        store,
    input  logic [31:0] wdata_in,
    output logic [3:0]  strobe,
    output logic [31:0] wdata,
    input  msize_t      ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_sign_ext,
    input  logic [31:0] rdata_in,
    output logic [31:0] rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: narrow data is replicated so every lane carries it and
    // the strobe alone picks the written bytes; loads never write.
    always_comb begin
        strobe = 4'b0000;
        wdata  = wdata_in;
        case (size)
            MSIZE1: begin
                strobe = 4'b0001 << addr_lo;
                wdata  = {4{wdata_in[7:0]}};
            end
            MSIZE2: begin
                strobe = 4'b0011 << {addr_lo[1], 1'b0};
                wdata  = {2{wdata_in[15:0]}};
            end
            default: begin
                strobe = 4'b1111;
                wdata  = wdata_in;
            end
        endcase
        if (!store) strobe = 4'b0000;
    end

    assign ld_byte = rdata_in[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = rdata_in[{ld_addr_lo[1], 4'b0000} +: 16];

    // Load side: pick the addressed lane and extend to 32 bits.
    always_comb begin
        rdata = rdata_in;
        case (ld_size)
            MSIZE1:  rdata = {{24{ld_sign_ext & ld_byte[7]}}, ld_byte};
            MSIZE2:  rdata = {{16{ld_sign_ext & ld_half[15]}}, ld_half};
            default: rdata = rdata_in;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MIPS memory stage: issues at most one data-bus access per instruction,
// stalls upstream while it is outstanding, registers results to writeback.
module memory_access
    import memory_access_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  content_t   in_cont,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       mem_stall,
    output content_t   out_cont,
    output logic       out_valid,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp
);

    mem_state_t  state, state_nxt;
    content_t    hold;
    logic [31:0] req_addr;
    msize_t      req_size;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        accept, is_mem, complete;
    logic [3:0]  strobe_w;
    logic [31:0] wdata_w, rdata_w;

    assign in_ready  = (state == IDLE);
    assign mem_stall = ~in_ready;
    assign accept    = in_valid & in_ready;
    assign is_mem    = in_cont.mem_control.read_en | in_cont.mem_control.write_en;

    mem_align u_align (
        .size        (in_cont.mem_control.size),
        .addr_lo     (in_cont.val.valE[1:0]),
        .store       (in_cont.mem_control.write_en),
        .wdata_in    (in_cont.val.valB),
        .strobe      (strobe_w),
        .wdata       (wdata_w),
        .ld_size     (hold.mem_control.size),
        .ld_addr_lo  (hold.val.valE[1:0]),
        .ld_sign_ext (hold.mem_control.sign_ext),
        .rdata_in    (dresp.data),
        .rdata       (rdata_w)
    );

    // Request fields come straight from registers so they stay stable while
    // the bus holds off addr_ok; valid depends on state alone.
    always_comb begin
        dreq        = '0;
        dreq.valid  = (state == REQ);
        dreq.addr   = req_addr;
        dreq.size   = req_size;
        dreq.strobe = req_strobe;
        dreq.data   = req_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state; data_ok outside REQ/WAIT is ignored by construction.
    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE: if (accept && is_mem) state_nxt = REQ;
            REQ: begin
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dresp.data_ok) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding/request registers and the memory/writeback pipeline register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_cont   <= '0;
            out_valid  <= 1'b0;
            hold       <= '0;
            req_addr   <= '0;
            req_size   <= MSIZE1;
            req_strobe <= '0;
            req_data   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    out_cont  <= in_cont;
                    out_valid <= 1'b1;
                end else begin
                    hold       <= in_cont;
                    req_addr   <= in_cont.val.valE;
                    req_size   <= in_cont.mem_control.size;
                    req_strobe <= strobe_w;
                    req_data   <= wdata_w;
                end
            end else if (complete) begin
                out_cont <= hold;
                if (hold.mem_control.read_en) out_cont.val.valM <= rdata_w;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized + directed bench for memory_access with a lane-arithmetic model.
module tb_memory_access;
    import memory_access_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    content_t   in_cont;
    logic       in_valid;
    logic       in_ready, mem_stall, out_valid;
    content_t   out_cont;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    int n_chk  = 0;
    int n_fail = 0;
    content_t last_out;

    memory_access dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_cont   (in_cont),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_stall (mem_stall),
        .out_cont  (out_cont),
        .out_valid (out_valid),
        .dreq      (dreq),
        .dresp     (dresp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic content_t mk(input bit rd, input bit wr, input bit sx,
                                    input int sz, input logic [31:0] e, input logic [31:0] b);
        content_t c;
        c.pc                   = $urandom;
        c.dst                  = 5'($urandom);
        c.mem_control.read_en  = rd;
        c.mem_control.write_en = wr;
        c.mem_control.sign_ext = sx;
        c.mem_control.size     = msize_t'(sz);
        c.val.valE             = e;
        c.val.valB             = b;
        c.val.valM             = $urandom;
        return c;
    endfunction

    // Reference model: bus lane rules as plain arithmetic.
    function automatic logic [3:0] m_strobe(input content_t c);
        int a = int'(c.val.valE[1:0]);
        if (!c.mem_control.write_en) return 4'd0;
        case (c.mem_control.size)
            MSIZE1:  return 4'(1 << a);
            MSIZE2:  return 4'(3 << (a & 2));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input content_t c);
        case (c.mem_control.size)
            MSIZE1:  return 32'(c.val.valB[7:0]) * 32'h01010101;
            MSIZE2:  return 32'(c.val.valB[15:0]) * 32'h00010001;
            default: return c.val.valB;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input content_t c, input logic [31:0] rd);
        int a = int'(c.val.valE[1:0]);
        logic [31:0] v;
        case (c.mem_control.size)
            MSIZE1: begin
                v = (rd >> (8 * a)) & 32'hff;
                if (c.mem_control.sign_ext && v >= 32'd128) v = v - 32'd256;
            end
            MSIZE2: begin
                v = (rd >> (8 * (a & 2))) & 32'hffff;
                if (c.mem_control.sign_ext && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic content_t m_out(input content_t c, input logic [31:0] rd);
        content_t r = c;
        if (c.mem_control.read_en) r.val.valM = m_load(c, rd);
        return r;
    endfunction

    // Issue one instruction, play the bus with the given waits, check all the way.
    task automatic run_op(input content_t c, input int aw, input int dw,
                          input bit same, input logic [31:0] rd);
        bit mem = c.mem_control.read_en | c.mem_control.write_en;
        in_cont  = c;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        in_cont  = mk(0, 0, 0, 0, $urandom, $urandom);
        if (!mem) begin
            chk("alu_valid", out_valid, 1);
            chk("alu_cont", out_cont, c);
            chk("alu_noreq", dreq.valid, 0);
            chk("alu_ready", in_ready, 1);
            last_out = c;
            return;
        end
        for (int i = 0; i <= aw; i++) begin
            chk("req_valid", dreq.valid, 1);
            chk("req_addr", dreq.addr, c.val.valE);
            chk("req_size", dreq.size, c.mem_control.size);
            chk("req_strobe", dreq.strobe, m_strobe(c));
            chk("req_data", dreq.data, m_wdata(c));
            chk("req_stall", mem_stall, 1);
            chk("req_ready", in_ready, 0);
            chk("req_outv", out_valid, 0);
            dresp.addr_ok = (i == aw);
            dresp.data_ok = (i == aw) && same;
            dresp.data    = ((i == aw) && same) ? rd : $urandom;
            @(posedge clk); @(negedge clk);
            dresp.addr_ok = 1'b0;
            dresp.data_ok = 1'b0;
        end
        if (!same) begin
            for (int i = 0; i <= dw; i++) begin
                chk("wait_novalid", dreq.valid, 0);
                chk("wait_ready", in_ready, 0);
                chk("wait_outv", out_valid, 0);
                dresp.data_ok = (i == dw);
                dresp.data    = (i == dw) ? rd : $urandom;
                @(posedge clk); @(negedge clk);
                dresp.data_ok = 1'b0;
            end
        end
        chk("done_valid", out_valid, 1);
        chk("done_cont", out_cont, m_out(c, rd));
        chk("done_ready", in_ready, 1);
        chk("done_stall", mem_stall, 0);
        last_out = m_out(c, rd);
        dresp.data = $urandom;
    endtask

    initial begin
        content_t c;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_cont  = '0;
        dresp    = '0;
        last_out = '0;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        chk("rst_outv", out_valid, 0);
        chk("rst_cont", out_cont, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_stall", mem_stall, 0);
        chk("rst_dreq", dreq, 0);

        // ALU op
        run_op(mk(0, 0, 0, 2, 32'h1234, 32'h0), 0, 0, 0, 32'h0);
        chk("alu_valE", out_cont.val.valE, 32'h1234);
        // lw zero wait
        run_op(mk(1, 0, 0, 2, 32'h80000004, 32'h0), 0, 0, 0, 32'hdeadbeef);
        chk("lw_valM", out_cont.val.valM, 32'hdeadbeef);
        // lb / lbu / lh
        run_op(mk(1, 0, 1, 0, 32'h10000003, 32'h0), 0, 1, 0, 32'h80aabbcc);
        chk("lb_valM", out_cont.val.valM, 32'hffffff80);
        run_op(mk(1, 0, 0, 0, 32'h10000003, 32'h0), 1, 0, 0, 32'h80aabbcc);
        chk("lbu_valM", out_cont.val.valM, 32'h00000080);
        run_op(mk(1, 0, 1, 1, 32'h10000002, 32'h0), 0, 0, 0, 32'h80011234);
        chk("lh_valM", out_cont.val.valM, 32'hffff8001);
        // sb with addr_ok held off 3 cycles
        c = mk(0, 1, 0, 0, 32'h20000001, 32'h000000ab);
        run_op(c, 3, 0, 0, 32'h0);
        chk("sb_strobe", dreq.strobe, 4'b0010);
        chk("sb_data", dreq.data, 32'habababab);
        chk("sb_valM", out_cont.val.valM, c.val.valM);
        // sw with addr_ok and data_ok together
        run_op(mk(0, 1, 0, 2, 32'h20000008, 32'h5a5a1234), 0, 0, 1, 32'h0);

        // reset while in WAIT, then a stray data_ok
        in_cont  = mk(1, 0, 0, 2, 32'h30000000, 32'h0);
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid      = 1'b0;
        dresp.addr_ok = 1'b1;
        @(posedge clk); @(negedge clk);
        dresp.addr_ok = 1'b0;
        chk("pre_rst_wait", in_ready, 0);
        resetn = 1'b0;
        @(posedge clk); @(negedge clk);
        resetn = 1'b1;
        chk("mid_rst_outv", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_dreqv", dreq.valid, 0);
        dresp.data_ok = 1'b1;
        dresp.data    = 32'hcafef00d;
        @(posedge clk); @(negedge clk);
        dresp.data_ok = 1'b0;
        chk("stray_outv", out_valid, 0);
        chk("stray_ready", in_ready, 1);
        chk("stray_cont", out_cont, 0);
        last_out = '0;
        run_op(mk(0, 0, 0, 2, 32'h4321, 32'h0), 0, 0, 0, 32'h0);

        // randomized mix, with idle gaps carrying stray data_ok
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 2);
            c = mk(kind == 1, kind == 2, $urandom_range(0, 1), $urandom_range(0, 2),
                   $urandom, $urandom);
            run_op(c, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                dresp.data_ok = 1'b1;
                dresp.addr_ok = $urandom_range(0, 1);
                @(posedge clk); @(negedge clk);
                dresp.data_ok = 1'b0;
                dresp.addr_ok = 1'b0;
                chk("gap_outv", out_valid, 0);
                chk("gap_hold", out_cont, last_out);
                chk("gap_ready", in_ready, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
